// File: rtl/serial_add_ctrl.sv
// Two-requester, round-robin arbitrated bit-serial adder (LSB first, one bit per clock).
// Optional signed-overflow output `ovf` when SERIAL_ADD_CTRL_OVF_EN is defined.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             rr_ptr;   // requester that wins when both request

   logic [1:0]       pick;
   logic             hs1, hc1, hs2, hc2, carry_nxt;
   logic             last_bit;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = rr_ptr ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
   end

   // Two cascaded half adders form the full-add cell for the current bit.
   always_comb begin
      hs1       = a_sr[0] ^ b_sr[0];
      hc1       = a_sr[0] & b_sr[0];
      hs2       = hs1 ^ carry;
      hc2       = hs1 & carry;
      carry_nxt = hc1 | hc2;
      last_bit  = (cnt == CW'(WIDTH - 1));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt    <= '0;
         busy   <= 1'b0;
         done   <= '0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
         ovf    <= 1'b0;
`endif
         a_sr   <= '0;
         b_sr   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         rr_ptr <= 1'b0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt    <= pick;
                  busy   <= 1'b1;
                  rr_ptr <= pick[0];
                  state  <= LOAD;
               end
            end
            LOAD: begin
               a_sr  <= gnt[1] ? a1 : a0;
               b_sr  <= gnt[1] ? b1 : b0;
               carry <= 1'b0;
               cnt   <= '0;
               sum   <= '0;
               cout  <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
               ovf   <= 1'b0;
`endif
               state <= SHIFT;
            end
            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               sum   <= {hs2, sum[WIDTH-1:1]};
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  cout  <= carry_nxt;
`ifdef SERIAL_ADD_CTRL_OVF_EN
                  ovf   <= carry ^ carry_nxt;   // carry into MSB vs carry out of MSB
`endif
                  done  <= gnt;
                  state <= DONE;
               end
            end
            DONE: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_done_in_gnt: assert property (@(posedge clk) disable iff (!rst_n) (done & ~gnt) == 2'b00);

endmodule
